// File: rtl/rf_arb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package rf_arb_pkg;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 64;

    localparam logic [AW-1:0] ZERO_REG = 5'd31;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam logic [1:0] REQ_WB  = 2'd0;
    localparam logic [1:0] REQ_LD  = 2'd1;
    localparam logic [1:0] REQ_MUL = 2'd2;
    localparam logic [1:0] REQ_EXC = 2'd3;

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Requester-side bus of the regfile write arbiter: requests in, grants and the
// registered write command out.
interface rf_write_arbiter_if;
    import rf_arb_pkg::*;

    // Handshake: requester i holds req[i], waddr_in and wdata_in stable until it
    // sees gnt[i]=1; a transfer happens on every cycle where req[i] & gnt[i].
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*AW-1:0] waddr_in;
    logic [NREQ*DW-1:0] wdata_in;
    logic               stall;
    logic [NREQ-1:0]    gnt;
    logic [1:0]         gnt_idx;
    logic               rf_we;
    logic [AW-1:0]      rf_waddr;
    logic [DW-1:0]      rf_wdata;
    logic               busy;
    arb_state_t         dbg_state;

    modport master (
        output req, lock, waddr_in, wdata_in, stall,
        input  gnt, gnt_idx, rf_we, rf_waddr, rf_wdata, busy, dbg_state
    );

    modport slave (
        input  req, lock, waddr_in, wdata_in, stall,
        output gnt, gnt_idx, rf_we, rf_waddr, rf_wdata, busy, dbg_state
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first request at or after ptr wins.
module rr_pick4
    import rf_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      idx,
    output logic            any
);

    logic [1:0] cand;

    // Walk from the farthest slot back to ptr so the nearest hit is written last.
    always_comb begin
        gnt  = '0;
        idx  = ptr;
        any  = 1'b0;
        cand = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
        if (any) begin
            gnt = idx_to_onehot(idx);
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single regfile write port, with owner lock and a
// one-cycle registered write command. Optional macro: RF_ZERO_REG_DROP_EN.
module rf_write_arbiter
    import rf_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    rf_write_arbiter_if.slave  bus
);

    arb_state_t      state, state_next;
    logic [1:0]      owner, owner_next;
    logic [1:0]      ptr, ptr_next;
    logic [NREQ-1:0] pick_gnt;
    logic [1:0]      pick_idx;
    logic            pick_any;
    logic [NREQ-1:0] gnt;
    logic [1:0]      gnt_idx;
    logic            grant;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;

    rr_pick4 u_pick (
        .req (bus.req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Reset forces gnt low combinationally, so nothing is accepted while held.
    always_comb begin
        state_next = state;
        owner_next = owner;
        ptr_next   = ptr;
        gnt        = '0;
        gnt_idx    = pick_idx;
        if (reset_n) begin
            case (state)
                IDLE: begin
                    if (!bus.stall && pick_any) begin
                        gnt      = pick_gnt;
                        ptr_next = pick_idx + 2'd1;
                        if (bus.lock[pick_idx]) begin
                            state_next = LOCKED;
                            owner_next = pick_idx;
                        end
                    end
                end
                LOCKED: begin
                    gnt_idx = owner;
                    if (bus.req[owner] && !bus.stall) begin
                        gnt = idx_to_onehot(owner);
                        if (!bus.lock[owner]) begin
                            state_next = IDLE;
                        end
                    end else if (!bus.req[owner] && !bus.lock[owner]) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign grant    = |gnt;
    assign sel_addr = bus.waddr_in[gnt_idx*AW +: AW];
    assign sel_data = bus.wdata_in[gnt_idx*DW +: DW];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            owner    <= REQ_WB;
            ptr      <= REQ_WB;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            ptr   <= ptr_next;
`ifdef RF_ZERO_REG_DROP_EN
            // X31 writes are accepted but never reach the regfile.
            if (grant && (sel_addr != ZERO_REG)) begin
                rf_we    <= 1'b1;
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end else begin
                rf_we <= 1'b0;
            end
`else
            if (grant) begin
                rf_we    <= 1'b1;
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end else begin
                rf_we <= 1'b0;
            end
`endif
        end
    end

    assign bus.gnt       = gnt;
    assign bus.gnt_idx   = gnt_idx;
    assign bus.rf_we     = rf_we;
    assign bus.rf_waddr  = rf_waddr;
    assign bus.rf_wdata  = rf_wdata;
    assign bus.busy      = reset_n && (state == LOCKED);
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_rf_write_arbiter;
    import rf_arb_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    rf_write_arbiter_if bus();

    rf_write_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Driver state: per-requester address/data and outstanding request flags.
    logic [AW-1:0]   a [NREQ];
    logic [DW-1:0]   d [NREQ];
    logic [NREQ-1:0] pend;

    task automatic apply(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l, input logic s);
        bus.req   = r;
        bus.lock  = l;
        bus.stall = s;
        for (int i = 0; i < NREQ; i++) begin
            bus.waddr_in[i*AW +: AW] = a[i];
            bus.wdata_in[i*DW +: DW] = d[i];
        end
    endtask

    // Behavioural model: pointer, lock owner, and the expected write command.
    int              m_ptr = 0;
    bit              m_locked = 1'b0;
    int              m_owner = 0;
    logic            m_we = 1'b0;
    logic [AW-1:0]   m_waddr = '0;
    logic [DW-1:0]   m_wdata = '0;
    int              wait_cnt [NREQ];
    bit              fair_en = 1'b0;
    logic [NREQ-1:0] last_gnt = '0;

    function automatic int model_pick();
        if (!reset_n) return -1;
        if (m_locked) return (bus.req[m_owner] && !bus.stall) ? m_owner : -1;
        if (bus.stall) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (bus.req[c]) return c;
        end
        return -1;
    endfunction

    int g_upd;
    logic [AW-1:0] ga;

    initial forever begin
        @(posedge clk);
        g_upd = model_pick();
        last_gnt = (g_upd >= 0) ? NREQ'(1 << g_upd) : '0;
        if (!reset_n) begin
            m_ptr = 0; m_locked = 0; m_owner = 0;
            m_we = 0; m_waddr = '0; m_wdata = '0;
            for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        end else begin
            if (g_upd >= 0) begin
                ga = bus.waddr_in[g_upd*AW +: AW];
`ifdef RF_ZERO_REG_DROP_EN
                m_we = (ga != 5'd31);
`else
                m_we = 1'b1;
`endif
                if (m_we) begin
                    m_waddr = ga;
                    m_wdata = bus.wdata_in[g_upd*DW +: DW];
                end
            end else begin
                m_we = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (g_upd == i || !bus.req[i]) wait_cnt[i] = 0;
                else if (!m_locked && !bus.stall) wait_cnt[i]++;
            end
            if (!m_locked) begin
                if (g_upd >= 0) begin
                    m_ptr = (g_upd + 1) % NREQ;
                    if (bus.lock[g_upd]) begin
                        m_locked = 1'b1;
                        m_owner = g_upd;
                    end
                end
            end else if (!bus.lock[m_owner] && (g_upd >= 0 || !bus.req[m_owner])) begin
                m_locked = 1'b0;
            end
        end
    end

    // Compare process: inputs change on the falling edge, outputs checked 2 ns later.
    int g_cmp;
    initial forever begin
        @(negedge clk);
        #2;
        g_cmp = model_pick();
        check("m_gnt", bus.gnt, (g_cmp >= 0) ? 64'(1 << g_cmp) : 64'd0);
        if (g_cmp >= 0) check("m_gnt_idx", bus.gnt_idx, 64'(g_cmp));
        check("m_busy", bus.busy, reset_n && m_locked);
        check("m_state", bus.dbg_state, m_locked ? LOCKED : IDLE);
        check("m_we", bus.rf_we, m_we);
        check("m_waddr", bus.rf_waddr, m_waddr);
        check("m_wdata", bus.rf_wdata, m_wdata);
        if (fair_en && g_cmp >= 0) check("m_fair_wait", wait_cnt[g_cmp] <= 3, 1);
    end

    logic [NREQ-1:0] lk;
    bit lock_en, rst_en;

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            a[i] = AW'(i + 4);
            d[i] = 64'h1000 + 64'(i);
            wait_cnt[i] = 0;
        end
        pend = '0;
        reset_n = 1'b0;
        apply(4'b1111, 4'b0000, 1'b0);

        // Reset held with all requests pending.
        repeat (3) begin
            @(negedge clk); #1;
            check("rst_gnt", bus.gnt, 0);
            check("rst_we", bus.rf_we, 0);
            check("rst_busy", bus.busy, 0);
        end

        // Round-robin sweep from ptr=0.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            reset_n = 1'b1;
            apply((k < 4) ? 4'b1111 : 4'b0000, 4'b0000, 1'b0);
            #1;
            if (k < 4) begin
                check("rr_gnt", bus.gnt, 64'(1 << k));
                check("rr_idx", bus.gnt_idx, 64'(k));
            end
            if (k > 0) begin
                check("rr_we", bus.rf_we, 1);
                check("rr_waddr", bus.rf_waddr, 64'(k + 3));
                check("rr_wdata", bus.rf_wdata, 64'h1000 + 64'(k - 1));
            end
        end

        // Load-return locks for three grants, releases on the fourth.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            apply((k < 4) ? 4'b0110 : 4'b0100, (k < 3) ? 4'b0010 : 4'b0000, 1'b0);
            #1;
            if (k < 4) check("lock_gnt", bus.gnt, 64'(1 << REQ_LD));
            else check("lock_after", bus.gnt, 64'(1 << REQ_MUL));
            if (k >= 1 && k < 4) check("lock_busy", bus.busy, 1);
            if (k == 4) check("lock_released", bus.busy, 0);
        end

        // Stall suppresses the multiplier's grant for two cycles.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            apply((k < 3) ? 4'b0100 : 4'b0000, 4'b0000, (k < 2));
            #1;
            if (k < 2) check("stall_gnt", bus.gnt, 0);
            if (k == 1) check("stall_we", bus.rf_we, 0);
            if (k == 2) check("stall_release_gnt", bus.gnt, 64'(1 << REQ_MUL));
            if (k == 3) begin
                check("stall_we_after", bus.rf_we, 1);
                check("stall_waddr", bus.rf_waddr, 64'(a[2]));
            end
        end

        // Exception writer locked, then a one-cycle reset pulse.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            reset_n = (k != 2);
            if (k < 3) apply(4'b1000, 4'b1000, 1'b0);
            else apply(4'b1001, 4'b0000, 1'b0);
            #1;
            if (k < 2) check("ml_gnt", bus.gnt, 64'(1 << REQ_EXC));
            if (k == 1) check("ml_busy", bus.busy, 1);
            if (k == 2) begin
                check("ml_rst_busy", bus.busy, 0);
                check("ml_rst_gnt", bus.gnt, 0);
            end
            if (k == 3) begin
                check("ml_first_gnt", bus.gnt, 64'(1 << REQ_WB));
                check("ml_busy_after", bus.busy, 0);
            end
        end

        // Write to the zero register from the WB stage.
        a[0] = 5'd31;
        d[0] = 64'hDEAD;
        @(negedge clk);
        apply(4'b0001, 4'b0000, 1'b0);
        #1;
        check("zr_gnt", bus.gnt, 64'b0001);
        @(negedge clk);
        apply(4'b0000, 4'b0000, 1'b0);
        #1;
`ifdef RF_ZERO_REG_DROP_EN
        check("zr_we", bus.rf_we, 0);
`else
        check("zr_we", bus.rf_we, 1);
        check("zr_waddr", bus.rf_waddr, 31);
        check("zr_wdata", bus.rf_wdata, 64'hDEAD);
`endif

        // Random traffic: phase 0 with locks and resets, phase 1 lock-free fairness.
        for (int phase = 0; phase < 2; phase++) begin
            lock_en = (phase == 0);
            rst_en = (phase == 0);
            if (phase == 1) begin
                for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
                fair_en = 1'b1;
            end
            for (int cyc = 0; cyc < 1500; cyc++) begin
                @(negedge clk);
                for (int i = 0; i < NREQ; i++) begin
                    if (pend[i] && last_gnt[i]) pend[i] = 1'b0;
                    if (!pend[i] && $urandom_range(0, 1) == 1) begin
                        pend[i] = 1'b1;
                        a[i] = ($urandom_range(0, 7) == 0) ? 5'd31 : AW'($urandom_range(0, 31));
                        d[i] = {$urandom, $urandom};
                    end
                    lk[i] = lock_en && ($urandom_range(0, 2) == 0);
                end
                reset_n = !(rst_en && $urandom_range(0, 199) == 0);
                apply(pend, lk, ($urandom_range(0, 7) == 0));
            end
        end

        @(negedge clk);
        reset_n = 1'b1;
        apply(4'b0000, 4'b0000, 1'b0);
        repeat (3) @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between four writeback requesters: 0 = WB stage, 1 = load-return, 2 = multiplier, 3 = exception/link writer.
- Round-robin arbitration with an optional multi-cycle lock.
- Produces a one-hot grant, a 2-bit grant index for the regfile write-enable decoder, and a registered write command (enable/address/data) one cycle after grant.

Parameters:
- NREQ, 4, number of requesters (fixed at 4; grant index is 2 bits).
- AW, 5, register address width (32 regs, X31 = zero register).
- DW, 64, write data width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- req  input  NREQ  per-requester write request.
- lock  input  NREQ  requester keeps the port after its current grant.
- waddr_in  input  NREQ*AW  per-requester address, requester i at bits [i*AW +: AW].
- wdata_in  input  NREQ*DW  per-requester data, requester i at bits [i*DW +: DW].
- stall  input  1  regfile busy; no grant this cycle.
- gnt  output  NREQ  one-hot grant, combinational, same cycle as accepted req.
- gnt_idx  output  2  encoded index of the granted requester (valid when gnt != 0).
- rf_we  output  1  registered write enable to the regfile.
- rf_waddr  output  AW  registered write address.
- rf_wdata  output  DW  registered write data.
- busy  output  1  lock currently held by some requester.

Behaviour:
- Reset, checked before all other logic:
  - Round-robin pointer ptr = 0.
  - Lock state IDLE, owner = 0.
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0.
  - gnt = 0 and busy = 0 during reset.
  - Reset mid-lock releases the lock immediately.
- Handshake:
  - A requester holds req, waddr_in and wdata_in stable until it sees gnt[i] = 1.
  - A transfer occurs on any cycle with req[i] & gnt[i].
  - At most one gnt bit is high per cycle; gnt[i] is never asserted without req[i].
- State machine:
  - IDLE:
    - If stall = 1, then gnt = 0.
    - Otherwise grant the first requester with req = 1, searching ptr, ptr+1, ... mod 4.
    - On grant to i: ptr <= (i+1) mod 4.
    - If lock[i] = 1, go to LOCKED with owner = i.
  - LOCKED:
    - Only the owner can be granted, and only when req[owner] & !stall.
    - Other requesters wait even if the owner is idle.
    - Leave to IDLE on the first granted cycle with lock[owner] = 0.
    - Also leave to IDLE if the owner drops req while lock = 0.
    - ptr is not updated while LOCKED.
  - busy = (state == LOCKED).
- Write path latency is 1 cycle. On a grant to i, the next cycle presents rf_we = 1, rf_waddr = waddr_in[i], rf_wdata = wdata_in[i]. Otherwise rf_we = 0 and address/data hold their previous values.
- stall = 1 suppresses grants in both states and does not alter ptr or owner; an already-registered write still completes.
- Simultaneous requests in IDLE: the rotating priority guarantees each requester is granted within 4 arbitration cycles (absent locks).

Optional Feature:
- Macro: RF_ZERO_REG_DROP_EN.
- Defined: a granted write with waddr_in = 5'd31 is accepted (gnt asserted, ptr advances) but produces rf_we = 0 next cycle.
- Undefined: X31 writes pass to the regfile unchanged, and the regfile discards them.

Decomposition:
- Shared package rf_arb_pkg holds:
  - constants NREQ, AW, DW, ZERO_REG = 5'd31;
  - enum arb_state_t {IDLE, LOCKED};
  - requester index constants REQ_WB, REQ_LD, REQ_MUL, REQ_EXC.
- One sub-module rr_pick4: a combinational rotating-priority picker.
  - Inputs: 4-bit request, 2-bit pointer.
  - Outputs: one-hot grant, 2-bit index, any-grant flag.
  - Instanced once; the lock and stall masking wraps it.

Test Plan:
- Reset: hold reset_n = 0 with req = 4'b1111 -> gnt = 0, rf_we = 0, busy = 0. After release, first grant is gnt = 4'b0001, gnt_idx = 0.
- Round-robin: req = 4'b1111 held for 4 cycles -> gnt sequence 0001, 0010, 0100, 1000. Each following cycle shows rf_we = 1 with the matching waddr/wdata.
- Lock: requester 1 asserts req and lock for 3 cycles, then lock = 0 on the 4th, while req[2] = 1 throughout.
  - gnt = 0010 for 4 consecutive cycles and busy = 1.
  - The next cycle gives gnt = 0100.
- Stall: req = 4'b0100, stall = 1 for 2 cycles -> gnt = 0 and rf_we = 0. Stall drops -> gnt = 0100, then rf_we = 1, rf_waddr = waddr_in[2].
- Reset mid-lock: owner 3 is LOCKED and reset_n pulses low for 1 cycle -> busy = 0, ptr = 0. With req = 4'b1001, the next grant is 0001.
- Zero register (macro defined): requester 0 writes waddr = 31, data = 64'hDEAD -> gnt = 0001 and next-cycle rf_we = 0. With the macro undefined -> rf_we = 1, rf_waddr = 31.
